// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    BREAK
  } rx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Width of a cycle counter that must hold values 0 .. clks-1.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous input; resets to all 1s (idle line).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb chain_d = {chain_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so each stage takes its predecessor's value from before the edge.
    if (reset) chain_q <= '1;
    else       chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_seq.sv
// UART receive sequencer: start detect, bit-centre timing, shift enables and stop check
// for an external 10-bit right-shifting frame register.
module uart_rx_seq
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_en,
  input  logic rx,
  output logic rx_sync,
  output logic shift_en,
  output logic busy,
  output logic byte_ready,
  output logic frame_err
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_seq: CLKS_PER_BIT must be in 4..65535");
  end

  localparam int unsigned CW   = cnt_width(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  // The strobe is registered, so it is requested one cycle before the terminal count;
  // the controller then checks rx_sync in the same cycle the shift register samples it.
  localparam logic [CW-1:0] HALF_M2   = CW'(HALF - 2);
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M2    = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          rx_prev_q;
  logic          shift_en_q, shift_en_d;
  logic          busy_q, busy_d;
  logic          byte_ready_q, byte_ready_d;
  logic          frame_err_q, frame_err_d;
  logic          fall;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  assign fall = rx_prev_q & ~rx_sync;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_en_d   = 1'b0;
    byte_ready_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_en && fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M2) shift_en_d = ~rx_sync;
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (shift_en_q && !rx_sync) ? DATA : IDLE;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_M2) shift_en_d = 1'b1;
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_DATA) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_M2) shift_en_d = 1'b1;
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = DONE;
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        // A start edge arriving during the output-latency cycle launches the next frame.
        byte_ready_d = 1'b1;
        cnt_d        = '0;
        state_d      = (rx_en && fall) ? START : IDLE;
      end
      BREAK: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts everything except a byte already complete in DONE.
    if (!rx_en && state_q != DONE) begin
      state_d     = IDLE;
      shift_en_d  = 1'b0;
      frame_err_d = 1'b0;
    end

    if (state_d == IDLE) begin
      cnt_d = '0;
      bit_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      rx_prev_q    <= 1'b1;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      rx_prev_q    <= rx_sync;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      byte_ready_q <= byte_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign byte_ready = byte_ready_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_seq.sv
// Directed bench for uart_rx_seq with a behavioural model of the downstream shift register.
module tb_uart_rx_seq;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset, rx_en, rx;
  logic rx_sync, shift_en, busy, byte_ready, frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_seq #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_en      (rx_en),
    .rx         (rx),
    .rx_sync    (rx_sync),
    .shift_en   (shift_en),
    .busy       (busy),
    .byte_ready (byte_ready),
    .frame_err  (frame_err)
  );

  // Downstream 10-bit right shift register with a registered byte output.
  logic [9:0] sr_q   = '1;
  logic [7:0] byte_q = '0;
  always @(posedge clk) begin
    if (shift_en) sr_q <= {rx_sync, sr_q[9:1]};
    byte_q <= sr_q[8:1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int         se_t[$], br_t[$], fe_t[$], fall_t[$], rise_t[$], brise_t[$], bfall_t[$];
  logic [7:0] br_byte[$];
  int         both_cnt  = 0;
  logic       prev_sync = 1'b1;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (shift_en) se_t.push_back(cyc);
    if (byte_ready) begin
      br_t.push_back(cyc);
      br_byte.push_back(byte_q);
    end
    if (frame_err) fe_t.push_back(cyc);
    if (byte_ready && frame_err) both_cnt <= both_cnt + 1;
    if (prev_sync && !rx_sync) fall_t.push_back(cyc);
    if (!prev_sync && rx_sync) rise_t.push_back(cyc);
    if (busy && !prev_busy) brise_t.push_back(cyc);
    if (!busy && prev_busy) bfall_t.push_back(cyc);
    prev_sync <= rx_sync;
    prev_busy <= busy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(stop_b, stop_len);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_en = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_sync, shift_en, busy, byte_ready, frame_err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {rx_sync, shift_en, busy, byte_ready, frame_err});
    end
    reset = 1'b0;
    idle(5);
    checks++;
    if ({busy, shift_en} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got busy/shift_en %b expected 00", {busy, shift_en});
    end
  endtask

  task automatic test_single_frame();
    int s0, r0, f0, fl0, bad;
    s0 = se_t.size(); r0 = br_t.size(); f0 = fe_t.size(); fl0 = fall_t.size();
    send_frame(8'h41, 1'b1, CPB);
    idle(10);
    checks++;
    if (se_t.size() - s0 !== FRAME_BITS) begin
      failures++;
      $display("FAIL a_pulse_count: got %0d expected %0d", se_t.size() - s0, FRAME_BITS);
    end
    if (se_t.size() > s0 && fall_t.size() > fl0) begin
      checks++;
      if (se_t[s0] - fall_t[fl0] !== HALF) begin
        failures++;
        $display("FAIL a_first_pulse_delay: got %0d expected %0d", se_t[s0] - fall_t[fl0], HALF);
      end
    end
    bad = 0;
    for (int i = s0 + 1; i < se_t.size(); i++)
      if (se_t[i] - se_t[i-1] != CPB) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL a_pulse_spacing: got %0d bad gaps expected 0", bad);
    end
    checks++;
    if (br_t.size() - r0 !== 1) begin
      failures++;
      $display("FAIL a_byte_ready_count: got %0d expected 1", br_t.size() - r0);
    end
    if (br_t.size() > r0 && se_t.size() > s0) begin
      checks++;
      if (br_t[r0] - se_t[se_t.size()-1] !== 2) begin
        failures++;
        $display("FAIL a_byte_ready_latency: got %0d expected 2", br_t[r0] - se_t[se_t.size()-1]);
      end
      checks++;
      if (br_byte[r0] !== 8'h41) begin
        failures++;
        $display("FAIL a_byte_value: got %h expected 41", br_byte[r0]);
      end
    end
    checks++;
    if (fe_t.size() - f0 !== 0) begin
      failures++;
      $display("FAIL a_frame_err: got %0d pulses expected 0", fe_t.size() - f0);
    end
  endtask

  task automatic test_glitch();
    int s0, r0, f0, fl0, b0, bf0;
    s0 = se_t.size(); r0 = br_t.size(); f0 = fe_t.size(); fl0 = fall_t.size();
    b0 = brise_t.size(); bf0 = bfall_t.size();
    send_bit(1'b0, 4);
    send_bit(1'b1, 30);
    checks++;
    if ((se_t.size() - s0) + (br_t.size() - r0) + (fe_t.size() - f0) !== 0) begin
      failures++;
      $display("FAIL glitch_strobes: got se=%0d br=%0d fe=%0d expected 0 0 0",
               se_t.size() - s0, br_t.size() - r0, fe_t.size() - f0);
    end
    checks++;
    if (brise_t.size() - b0 !== 1 || bfall_t.size() - bf0 !== 1) begin
      failures++;
      $display("FAIL glitch_busy_edges: got rises=%0d falls=%0d expected 1 1",
               brise_t.size() - b0, bfall_t.size() - bf0);
    end else begin
      checks++;
      if (bfall_t[bf0] - brise_t[b0] !== HALF) begin
        failures++;
        $display("FAIL glitch_busy_width: got %0d expected %0d", bfall_t[bf0] - brise_t[b0], HALF);
      end
      if (fall_t.size() > fl0) begin
        checks++;
        if (brise_t[b0] - fall_t[fl0] !== 1) begin
          failures++;
          $display("FAIL glitch_busy_rise: got %0d expected 1", brise_t[b0] - fall_t[fl0]);
        end
      end
    end
  endtask

  task automatic test_frame_error();
    int s0, r0, f0, bf0;
    s0 = se_t.size(); r0 = br_t.size(); f0 = fe_t.size(); bf0 = bfall_t.size();
    send_frame(8'h5A, 1'b0, 40);
    send_bit(1'b1, 10);
    checks++;
    if (se_t.size() - s0 !== FRAME_BITS || fe_t.size() - f0 !== 1 || br_t.size() - r0 !== 0) begin
      failures++;
      $display("FAIL ferr_counts: got se=%0d fe=%0d br=%0d expected 10 1 0",
               se_t.size() - s0, fe_t.size() - f0, br_t.size() - r0);
    end
    if (fe_t.size() > f0 && se_t.size() > s0) begin
      checks++;
      if (fe_t[f0] - se_t[se_t.size()-1] !== 1) begin
        failures++;
        $display("FAIL ferr_latency: got %0d expected 1", fe_t[f0] - se_t[se_t.size()-1]);
      end
    end
    checks++;
    if (bfall_t.size() - bf0 !== 1) begin
      failures++;
      $display("FAIL ferr_busy_falls: got %0d expected 1", bfall_t.size() - bf0);
    end else if (rise_t.size() > 0) begin
      checks++;
      if (bfall_t[bf0] - rise_t[rise_t.size()-1] !== 1) begin
        failures++;
        $display("FAIL ferr_busy_release: got %0d expected 1",
                 bfall_t[bf0] - rise_t[rise_t.size()-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s0, r0, f0;
    s0 = se_t.size(); r0 = br_t.size(); f0 = fe_t.size();
    send_frame(8'h55, 1'b1, CPB);
    send_frame(8'hAA, 1'b1, CPB);
    idle(10);
    checks++;
    if (se_t.size() - s0 !== 2 * FRAME_BITS || fe_t.size() - f0 !== 0) begin
      failures++;
      $display("FAIL b2b_counts: got se=%0d fe=%0d expected 20 0",
               se_t.size() - s0, fe_t.size() - f0);
    end
    checks++;
    if (br_t.size() - r0 !== 2) begin
      failures++;
      $display("FAIL b2b_byte_ready_count: got %0d expected 2", br_t.size() - r0);
    end else begin
      checks++;
      if (br_byte[r0] !== 8'h55 || br_byte[r0+1] !== 8'hAA) begin
        failures++;
        $display("FAIL b2b_bytes: got %h %h expected 55 aa", br_byte[r0], br_byte[r0+1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int s0, r0;
    d  = 8'h33;
    s0 = se_t.size();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
    checks++;
    if (se_t.size() - s0 !== 5) begin
      failures++;
      $display("FAIL rst_pre_pulses: got %0d expected 5", se_t.size() - s0);
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, shift_en, rx_sync} !== 3'b001) begin
      failures++;
      $display("FAIL rst_abort: got busy/shift_en/rx_sync %b expected 001", {busy, shift_en, rx_sync});
    end
    reset = 1'b0;
    idle(30);
    checks++;
    if (se_t.size() - s0 !== 5) begin
      failures++;
      $display("FAIL rst_no_more_pulses: got %0d expected 5", se_t.size() - s0);
    end
    r0 = br_t.size();
    send_frame(8'h33, 1'b1, CPB);
    idle(10);
    checks++;
    if (br_t.size() - r0 !== 1) begin
      failures++;
      $display("FAIL rst_next_frame_count: got %0d expected 1", br_t.size() - r0);
    end else begin
      checks++;
      if (br_byte[r0] !== 8'h33) begin
        failures++;
        $display("FAIL rst_next_frame_byte: got %h expected 33", br_byte[r0]);
      end
    end
  endtask

  task automatic test_rx_en_drop();
    logic [7:0] d;
    int s0, r0, f0;
    d  = 8'h7E;
    s0 = se_t.size(); r0 = br_t.size(); f0 = fe_t.size();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 2; i++) send_bit(d[i], CPB);
    checks++;
    if (se_t.size() - s0 !== 3) begin
      failures++;
      $display("FAIL en_pre_pulses: got %0d expected 3", se_t.size() - s0);
    end
    rx_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, shift_en} !== 2'b00) begin
      failures++;
      $display("FAIL en_abort: got busy/shift_en %b expected 00", {busy, shift_en});
    end
    for (int i = 2; i < 8; i++) send_bit(d[i], CPB);
    send_bit(1'b1, CPB);
    checks++;
    if (se_t.size() - s0 !== 3 || br_t.size() - r0 !== 0 || fe_t.size() - f0 !== 0) begin
      failures++;
      $display("FAIL en_disabled_strobes: got se=%0d br=%0d fe=%0d expected 3 0 0",
               se_t.size() - s0, br_t.size() - r0, fe_t.size() - f0);
    end
    rx_en = 1'b1;
    idle(5);
    send_frame(8'h7E, 1'b1, CPB);
    idle(10);
    checks++;
    if (br_t.size() - r0 !== 1) begin
      failures++;
      $display("FAIL en_next_frame_count: got %0d expected 1", br_t.size() - r0);
    end else begin
      checks++;
      if (br_byte[r0] !== 8'h7E) begin
        failures++;
        $display("FAIL en_next_frame_byte: got %h expected 7e", br_byte[r0]);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL ready_err_overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_en = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_rx_en_drop();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_seq.md
Name: uart_rx_seq

Overview:
- Receive-side sequencer for the serial-in ASCII shift register, which is 10 bits wide, shifts right, and registers bits [8:1] onto its byte output.
- Synchronises the raw serial line and detects the start bit.
- Times bit-centre sampling and drives the shift register's enable with exactly 10 pulses per frame: start, 8 data bits LSB-first, stop.
- Checks the stop bit, then flags byte-ready or framing error. Sits between the UART pin and the shift register, upstream of the ASCII consumer.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Legal range is 4 to 65535; elaboration fails outside that range.
- SYNC_STAGES, 2: flip-flop depth of the rx synchroniser. Minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_en  in  1  receiver enable. Low forces IDLE.
- rx  in  1  asynchronous serial line, idle high.
- rx_sync  out  1  synchronised rx, wired to the shift register's ascii input.
- shift_en  out  1  one-cycle sample strobe, wired to the shift register's enable.
- busy  out  1  high in any state other than IDLE.
- byte_ready  out  1  one-cycle pulse: the shift register's byte output holds a valid byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset: state is IDLE, all counters are 0, and the synchroniser chain is all 1s.
  - Outputs under reset: rx_sync=1, shift_en=0, busy=0, byte_ready=0, frame_err=0.
  - Reset mid-frame aborts at that edge with no further pulses.
- rx_sync is the final synchroniser stage. All decisions use rx_sync only, never rx.
- All outputs are registered. shift_en is high for exactly one cycle. The shift register samples rx_sync at the end of that cycle, and the controller's checks use that same rx_sync value.
- HALF = CLKS_PER_BIT/2, rounded down. The cycle counter is $clog2(CLKS_PER_BIT) bits wide. The bit counter is 4 bits wide.
- IDLE:
  - A falling edge of rx_sync (previous 1, current 0) with rx_en=1 moves to START with cycle counter = 0.
  - A line that is already low on leaving reset is not a start; a 1→0 transition is required.
- START:
  - Count to HALF-1. On that cycle:
    - If rx_sync=0: pulse shift_en (start bit), reset the cycle counter, go to DATA.
    - Otherwise it was a glitch: no pulse, go to IDLE.
- DATA:
  - Every CLKS_PER_BIT cycles, pulse shift_en and increment the bit counter.
  - After the 8th data pulse, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, pulse shift_en (10th pulse).
  - If rx_sync=1, go to DONE.
  - If rx_sync=0, pulse frame_err on the next cycle and go to BREAK.
- DONE:
  - Waits one cycle to cover the shift register's one-cycle output latency.
  - byte_ready pulses two cycles after the 10th shift_en cycle, then the block returns to IDLE.
  - A falling edge seen in that same cycle is not lost: it is held and a new frame starts next cycle, supporting back-to-back frames with a minimal stop bit.
- BREAK:
  - Hold until rx_sync=1, then go to IDLE. No shift_en pulses while in BREAK.
- rx_en=0 in any state goes to IDLE at the next edge: counters clear, no strobes. A frame already in DONE still delivers byte_ready.
- byte_ready and frame_err are never high in the same cycle. At most one of them fires per frame.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE, START, DATA, STOP, DONE, BREAK.
  - FRAME_BITS=10 and DATA_BITS=8.
  - Function returning the counter width for a given CLKS_PER_BIT.
- One sub-module, sync_ff: a parameterised SYNC_STAGES synchroniser with reset value 1.
- The shift register is instantiated alongside this block at the top level, not inside it.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Send 0x41 ('A', frame 0,1000 0010,1): 10 shift_en pulses, the first 8 cycles after the rx_sync fall, then spaced 16 cycles apart. byte_ready pulses once, 2 cycles after the 10th pulse. The shift register's byte output = 0x41. frame_err stays 0.
- rx low for 4 cycles, then high: busy rises and returns to 0 at cycle HALF. No shift_en, byte_ready or frame_err.
- Frame 0x5A with the stop bit driven 0 and held low for 40 cycles: 10 shift_en pulses, then one frame_err pulse and no byte_ready. busy stays high until rx_sync returns to 1, then drops.
- Back-to-back 0x55 then 0xAA, the second start edge immediately after a 16-cycle stop: 20 shift_en pulses and 2 byte_ready pulses. The byte output reads 0x55, then 0xAA.
- reset asserted after the 4th data pulse: next cycle busy=0 and shift_en=0. A following 0x33 frame is received correctly.
- rx_en dropped after the 2nd data pulse: busy=0 next cycle and no further strobes. With rx_en raised again, a subsequent 0x7E frame yields byte_ready with 0x7E.
